xlate_tlb: RTL and testbench
============================

XLATE_TLB -- requirements
Module: xlate_tlb

Interface
REQ-001 SHALL have parameter ENTRIES, default 8, meaning number of TLB entries (power of 2, 2..32).
REQ-002 SHALL have parameter PAGE_BITS, default 12, meaning page offset width (12..16); VPN/PFN width = 32-PAGE_BITS.
REQ-003 SHALL have parameter ASID_W, default 8, meaning address-space ID width.
REQ-004 SHALL have ports: clk in 1, rising-edge clock; reset in 1, synchronous active-high reset (one clock; reset synchronous, active-high).
REQ-005 SHALL have ports: req_valid in 1; req_ready out 1; req_vaddr in 32; req_asid in ASID_W; req_user in 1, 1 = user mode.
REQ-006 SHALL have ports: resp_valid out 1; resp_ready in 1; resp_paddr out 32; resp_miss out 1; resp_addr_err out 1; resp_uncached out 1.
REQ-007 SHALL have ports: tlbw_en in 1; tlbw_index in log2(ENTRIES); tlbw_vpn in 32-PAGE_BITS; tlbw_asid in ASID_W; tlbw_global in 1; tlbw_pfn in 32-PAGE_BITS; tlbw_valid in 1.
REQ-008 SHALL have ports: flush in 1, invalidate all entries; miss_count out 16, saturating miss counter.

Function
REQ-009 SHALL decode segments: kuseg 0x0000_0000-0x7FFF_FFFF mapped; kseg0 0x8000_0000-0x9FFF_FFFF unmapped cached; kseg1 0xA000_0000-0xBFFF_FFFF unmapped uncached; kseg2/kseg3 0xC000_0000-0xFFFF_FFFF mapped.
REQ-010 SHALL for kseg0/kseg1 return paddr = vaddr & 0x1FFF_FFFF, miss=0; uncached=1 for kseg1 only.
REQ-011 SHALL for mapped segments hit entry i when valid[i] && vpn[i]==vaddr[31:PAGE_BITS] && (global[i] || asid[i]==req_asid); paddr = {pfn[i], vaddr[PAGE_BITS-1:0]}, uncached=0.
REQ-012 SHALL on multiple hits select lowest index.
REQ-013 SHALL on no hit in mapped segment set miss=1, paddr=0.
REQ-014 SHALL set addr_err=1, miss=0, paddr=0 when req_user=1 and vaddr[31]=1; addr_err overrides all other results.
REQ-015 SHALL accept request when req_valid && req_ready; response registered, resp_valid asserted exactly 1 cycle after acceptance.
REQ-016 SHALL drive req_ready = !resp_valid || resp_ready (single-stage pipeline, back-to-back throughput 1/cycle).
REQ-017 SHALL hold all resp_* stable while resp_valid && !resp_ready.
REQ-018 SHALL clear resp_valid on resp_ready when no new request accepted same cycle.
REQ-019 SHALL apply tlbw write at the clock edge; lookup accepted in the same cycle sees pre-write contents.
REQ-020 SHALL on flush clear all valid bits at the clock edge; flush and tlbw_en same cycle -> all entries invalid (flush wins); lookup same cycle sees pre-flush contents.
REQ-021 SHALL increment miss_count by 1 on each accepted request producing resp_miss=1, saturating at 0xFFFF; addr_err does not count.
REQ-022 SHALL not alter TLB contents or miss_count on lookups other than REQ-021.

Reset
REQ-023 SHALL on reset: resp_valid=0, resp_paddr=0, resp_miss=0, resp_addr_err=0, resp_uncached=0, all valid bits=0, miss_count=0.
REQ-024 SHALL on reset mid-operation discard pending response; req_ready=1 in first cycle after reset deasserts.
REQ-025 SHALL give reset priority over flush, tlbw_en and request acceptance.

Verification
REQ-026 kseg0/kseg1: vaddr 0x8000_1234 then 0xA000_1234 -> paddr 0x0000_1234 uncached=0, then paddr 0x0000_1234 uncached=1, each 1 cycle later.
REQ-027 TLB hit: write idx 3 vpn 0x00400 asid 5 pfn 0x12345 valid; lookup 0x0040_0ABC asid 5 -> paddr 0x1234_5ABC; asid 6 -> miss=1, miss_count=1; same with global=1 -> hit.
REQ-028 User fault: req_user=1 vaddr 0xC000_0000 -> addr_err=1, miss_count unchanged.
REQ-029 Backpressure: 3 back-to-back requests, resp_ready low 2 cycles -> req_ready low, first response held stable, all 3 responses delivered in order.
REQ-030 Write/flush collision: lookup vpn X with tlbw to X same cycle -> miss; next-cycle lookup -> hit; flush+tlbw same cycle -> later lookup misses.
REQ-031 Saturation/reset: force 65536 misses -> miss_count=0xFFFF holds; reset with resp_valid=1 -> resp_valid=0, miss_count=0 next cycle.

Source files
------------

// File: rtl/xlate_tlb.sv
`timescale 1ns/1ps
// xlate_tlb: single-stage MIPS-style address translator with a small fully
// associative TLB.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   req_*               lookup request (valid/ready). Fields: vaddr, asid, user
//   resp_*              registered lookup result (valid/ready). Fields: paddr,
//                       miss, addr_err, uncached
//   tlbw_*              single-entry TLB write port
//   flush               invalidate every entry
//   miss_count          saturating count of accepted requests that missed
//
// The lookup is combinational from the request and the current TLB contents.
// Its result is captured in one register stage. A write or flush in the same
// cycle therefore takes effect only for later lookups.
module xlate_tlb #(
  parameter int ENTRIES   = 8,
  parameter int PAGE_BITS = 12,
  parameter int ASID_W    = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [31:0]                req_vaddr,
  input  logic [ASID_W-1:0]          req_asid,
  input  logic                       req_user,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [31:0]                resp_paddr,
  output logic                       resp_miss,
  output logic                       resp_addr_err,
  output logic                       resp_uncached,
  input  logic                       tlbw_en,
  input  logic [$clog2(ENTRIES)-1:0] tlbw_index,
  input  logic [31-PAGE_BITS:0]      tlbw_vpn,
  input  logic [ASID_W-1:0]          tlbw_asid,
  input  logic                       tlbw_global,
  input  logic [31-PAGE_BITS:0]      tlbw_pfn,
  input  logic                       tlbw_valid,
  input  logic                       flush,
  output logic [15:0]                miss_count
);

  localparam int VPN_W = 32 - PAGE_BITS;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // TLB storage. Only the valid bits are control state; the tag and data
  // fields need no reset because an entry is ignored until marked valid.
  logic [ENTRIES-1:0] ent_valid;
  logic [VPN_W-1:0]   ent_vpn    [ENTRIES];
  logic [ASID_W-1:0]  ent_asid   [ENTRIES];
  logic               ent_global [ENTRIES];
  logic [VPN_W-1:0]   ent_pfn    [ENTRIES];

  // ---- stage p0: combinational lookup on the incoming request ----
  logic               accept_p0;
  logic [VPN_W-1:0]   vpn_p0;
  logic               hit_p0;
  logic [VPN_W-1:0]   hit_pfn_p0;
  logic [31:0]        paddr_p0;
  logic               miss_p0;
  logic               err_p0;
  logic               unc_p0;

  logic               vld_p1;
  logic [31:0]        paddr_p1;
  logic               miss_p1;
  logic               err_p1;
  logic               unc_p1;
  logic [15:0]        miss_cnt_p1;

  assign req_ready = !vld_p1 || resp_ready;
  assign accept_p0 = req_valid && req_ready;
  assign vpn_p0    = req_vaddr[31:PAGE_BITS];

  // Scan upward and keep the first match so the lowest index wins.
  always_comb begin
    hit_p0     = 1'b0;
    hit_pfn_p0 = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (!hit_p0 && ent_valid[i] && (ent_vpn[i] == vpn_p0) &&
          (ent_global[i] || (ent_asid[i] == req_asid))) begin
        hit_p0     = 1'b1;
        hit_pfn_p0 = ent_pfn[i];
      end
    end
  end

  // Segment decode. vaddr[31:30]==2'b10 covers kseg0/kseg1 (unmapped);
  // bit 29 then selects kseg1, the uncached window.
  always_comb begin
    paddr_p0 = '0;
    miss_p0  = 1'b0;
    err_p0   = 1'b0;
    unc_p0   = 1'b0;
    if (req_user && req_vaddr[31]) begin
      err_p0 = 1'b1;
    end else if (req_vaddr[31:30] == 2'b10) begin
      paddr_p0 = {3'b000, req_vaddr[28:0]};
      unc_p0   = req_vaddr[29];
    end else if (hit_p0) begin
      paddr_p0 = {hit_pfn_p0, req_vaddr[PAGE_BITS-1:0]};
    end else begin
      miss_p0 = 1'b1;
    end
  end

  // ---- stage p1: registered response and miss counter ----
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1      <= 1'b0;
      paddr_p1    <= '0;
      miss_p1     <= 1'b0;
      err_p1      <= 1'b0;
      unc_p1      <= 1'b0;
      miss_cnt_p1 <= '0;
    end else begin
      if (accept_p0) begin
        vld_p1   <= 1'b1;
        paddr_p1 <= paddr_p0;
        miss_p1  <= miss_p0;
        err_p1   <= err_p0;
        unc_p1   <= unc_p0;
        if (miss_p0)
          miss_cnt_p1 <= sat_inc(miss_cnt_p1);
      end else if (resp_ready) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  // TLB valid bits: reset beats flush, flush beats a write.
  always_ff @(posedge clk) begin
    if (reset || flush)
      ent_valid <= '0;
    else if (tlbw_en)
      ent_valid[tlbw_index] <= tlbw_valid;
  end

  // Tag/data fields may be written during a flush; the entry stays invalid.
  always_ff @(posedge clk) begin
    if (tlbw_en) begin
      ent_vpn[tlbw_index]    <= tlbw_vpn;
      ent_asid[tlbw_index]   <= tlbw_asid;
      ent_global[tlbw_index] <= tlbw_global;
      ent_pfn[tlbw_index]    <= tlbw_pfn;
    end
  end

  assign resp_valid    = vld_p1;
  assign resp_paddr    = paddr_p1;
  assign resp_miss     = miss_p1;
  assign resp_addr_err = err_p1;
  assign resp_uncached = unc_p1;
  assign miss_count    = miss_cnt_p1;

endmodule

// File: tb/tb_xlate_tlb.sv
`timescale 1ns/1ps
module tb_xlate_tlb;
  localparam int ENTRIES   = 8;
  localparam int PAGE_BITS = 12;
  localparam int ASID_W    = 8;
  localparam int IDX_W     = $clog2(ENTRIES);
  localparam int VPN_W     = 32 - PAGE_BITS;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, req_valid, req_ready, req_user;
  logic [31:0]       req_vaddr;
  logic [ASID_W-1:0] req_asid;
  logic              resp_valid, resp_ready, resp_miss, resp_addr_err, resp_uncached;
  logic [31:0]       resp_paddr;
  logic              tlbw_en, tlbw_global, tlbw_valid, flush;
  logic [IDX_W-1:0]  tlbw_index;
  logic [VPN_W-1:0]  tlbw_vpn, tlbw_pfn;
  logic [ASID_W-1:0] tlbw_asid;
  logic [15:0]       miss_count;

  xlate_tlb #(.ENTRIES(ENTRIES), .PAGE_BITS(PAGE_BITS), .ASID_W(ASID_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_vaddr(req_vaddr),
    .req_asid(req_asid), .req_user(req_user),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_paddr(resp_paddr),
    .resp_miss(resp_miss), .resp_addr_err(resp_addr_err), .resp_uncached(resp_uncached),
    .tlbw_en(tlbw_en), .tlbw_index(tlbw_index), .tlbw_vpn(tlbw_vpn),
    .tlbw_asid(tlbw_asid), .tlbw_global(tlbw_global), .tlbw_pfn(tlbw_pfn),
    .tlbw_valid(tlbw_valid), .flush(flush), .miss_count(miss_count)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference model: a list of entries plus the expected response register.
  typedef struct packed {
    logic [31:0] paddr;
    logic        miss;
    logic        err;
    logic        unc;
  } res_t;

  logic              m_valid [ENTRIES];
  logic [VPN_W-1:0]  m_vpn   [ENTRIES];
  logic [ASID_W-1:0] m_asid  [ENTRIES];
  logic              m_glob  [ENTRIES];
  logic [VPN_W-1:0]  m_pfn   [ENTRIES];
  logic              m_rv;
  res_t              m_res;
  int                m_mc;
  logic [31:0]       got_q[$];
  logic              cap;

  function automatic res_t ref_xlate(input logic [31:0] va, input logic [ASID_W-1:0] as,
                                     input logic usr);
    res_t r;
    r = '0;
    if (usr && va >= 32'h8000_0000) begin
      r.err = 1'b1;
      return r;
    end
    if (va >= 32'h8000_0000 && va < 32'hC000_0000) begin
      r.paddr = va % 32'h2000_0000;
      r.unc   = (va >= 32'hA000_0000);
      return r;
    end
    for (int i = 0; i < ENTRIES; i++) begin
      if (m_valid[i] && (32'(m_vpn[i]) == (va >> PAGE_BITS)) &&
          (m_glob[i] || m_asid[i] == as)) begin
        r.paddr = (32'(m_pfn[i]) << PAGE_BITS) + (va % (32'd1 << PAGE_BITS));
        return r;
      end
    end
    r.miss = 1'b1;
    return r;
  endfunction

  // One clock: called just after a falling edge with inputs already driven.
  task automatic step(output logic acc);
    res_t r;
    logic was_rst;
    #1;
    if (!reset) chk("req_ready", req_ready, !m_rv || resp_ready);
    if (cap && !reset && resp_valid && resp_ready) got_q.push_back(resp_paddr);
    acc = !reset && req_valid && (!m_rv || resp_ready);
    r = ref_xlate(req_vaddr, req_asid, req_user);
    was_rst = reset;
    @(posedge clk);
    if (reset) begin
      m_rv  = 1'b0;
      m_res = '0;
      m_mc  = 0;
      for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
    end else begin
      if (acc) begin
        m_rv  = 1'b1;
        m_res = r;
        if (r.miss && m_mc < 65535) m_mc++;
      end else if (resp_ready) begin
        m_rv = 1'b0;
      end
      if (flush) begin
        for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
      end else if (tlbw_en) begin
        m_valid[tlbw_index] = tlbw_valid;
        m_vpn[tlbw_index]   = tlbw_vpn;
        m_asid[tlbw_index]  = tlbw_asid;
        m_glob[tlbw_index]  = tlbw_global;
        m_pfn[tlbw_index]   = tlbw_pfn;
      end
    end
    @(negedge clk);
    chk("resp_valid", resp_valid, m_rv);
    chk("miss_count", miss_count, 32'(m_mc));
    if (m_rv || was_rst) begin
      chk("resp_paddr", resp_paddr, m_res.paddr);
      chk("resp_miss", resp_miss, m_res.miss);
      chk("resp_addr_err", resp_addr_err, m_res.err);
      chk("resp_uncached", resp_uncached, m_res.unc);
    end
  endtask

  task automatic tick();
    logic a;
    step(a);
  endtask

  task automatic idle();
    reset = 0; req_valid = 0; req_vaddr = '0; req_asid = '0; req_user = 0;
    resp_ready = 1; tlbw_en = 0; tlbw_index = '0; tlbw_vpn = '0; tlbw_asid = '0;
    tlbw_global = 0; tlbw_pfn = '0; tlbw_valid = 0; flush = 0;
  endtask

  task automatic set_req(input logic [31:0] va, input logic [ASID_W-1:0] as, input logic usr);
    req_valid = 1; req_vaddr = va; req_asid = as; req_user = usr;
  endtask

  task automatic set_w(input int idx, input logic [VPN_W-1:0] vpn, input logic [ASID_W-1:0] as,
                       input logic g, input logic [VPN_W-1:0] pfn, input logic v);
    tlbw_en = 1; tlbw_index = IDX_W'(idx); tlbw_vpn = vpn; tlbw_asid = as;
    tlbw_global = g; tlbw_pfn = pfn; tlbw_valid = v;
  endtask

  logic [VPN_W-1:0] vpn_pool [4];
  logic a;
  int   n;

  initial begin
    vpn_pool[0] = 20'h00400; vpn_pool[1] = 20'h00401;
    vpn_pool[2] = 20'hC0000; vpn_pool[3] = 20'hFFFFF;
    m_rv = 0; m_res = '0; m_mc = 0; cap = 0;
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0; m_vpn[i] = '0; m_asid[i] = '0; m_glob[i] = 0; m_pfn[i] = '0;
    end
    idle();
    reset = 1;
    @(negedge clk);
    tick();
    tick();
    reset = 0;

    // Unmapped segments
    set_req(32'h8000_1234, 8'd0, 0); tick();
    chk("k0_paddr", resp_paddr, 32'h0000_1234); chk("k0_unc", resp_uncached, 0);
    set_req(32'hA000_1234, 8'd0, 0); tick();
    chk("k1_paddr", resp_paddr, 32'h0000_1234); chk("k1_unc", resp_uncached, 1);

    // TLB hit / asid miss / global hit
    idle(); set_w(3, 20'h00400, 8'd5, 0, 20'h12345, 1); tick(); idle();
    set_req(32'h0040_0ABC, 8'd5, 0); tick();
    chk("hit_paddr", resp_paddr, 32'h1234_5ABC); chk("hit_miss", resp_miss, 0);
    set_req(32'h0040_0ABC, 8'd6, 0); tick();
    chk("asid_miss", resp_miss, 1); chk("asid_paddr", resp_paddr, 0);
    chk("asid_mc", miss_count, 1);
    idle(); set_w(3, 20'h00400, 8'd5, 1, 20'h12345, 1); tick(); idle();
    set_req(32'h0040_0ABC, 8'd6, 0); tick();
    chk("glob_hit", resp_paddr, 32'h1234_5ABC); chk("glob_miss", resp_miss, 0);

    // User access to kernel space
    set_req(32'hC000_0000, 8'd0, 1); tick();
    chk("uerr_err", resp_addr_err, 1); chk("uerr_miss", resp_miss, 0);
    chk("uerr_mc", miss_count, 1);

    // Write/lookup collision, then flush beats write
    idle(); set_w(0, 20'h00500, 8'd1, 0, 20'h00ABC, 1);
    set_req(32'h0050_0123, 8'd1, 0); tick(); tlbw_en = 0;
    chk("coll_miss", resp_miss, 1);
    tick();
    chk("coll_hit", resp_paddr, 32'h00AB_C123); chk("coll_hitm", resp_miss, 0);
    idle(); flush = 1; set_w(1, 20'h00600, 8'd1, 0, 20'h00001, 1); tick(); idle();
    set_req(32'h0050_0123, 8'd1, 0); tick(); chk("fl_miss0", resp_miss, 1);
    set_req(32'h0060_0000, 8'd1, 0); tick(); chk("fl_miss1", resp_miss, 1);

    // Backpressure: three back-to-back requests, two stalled cycles
    idle(); tick();
    got_q.delete(); cap = 1; n = 0;
    for (int c = 0; c < 10; c++) begin
      resp_ready = !(c == 1 || c == 2);
      case (n)
        0: set_req(32'h8000_0010, 8'd0, 0);
        1: set_req(32'h8000_0020, 8'd0, 0);
        2: set_req(32'hA000_0030, 8'd0, 0);
        default: req_valid = 0;
      endcase
      step(a);
      if (a) n++;
      if (c == 2) chk("bp_held", resp_paddr, 32'h10);
    end
    cap = 0;
    chk("bp_count", got_q.size(), 3);
    if (got_q.size() == 3) begin
      chk("bp_r0", got_q[0], 32'h10); chk("bp_r1", got_q[1], 32'h20);
      chk("bp_r2", got_q[2], 32'h30);
    end

    // Miss counter saturation
    idle(); flush = 1; tick(); idle();
    set_req(32'h0000_1000, 8'd0, 0);
    for (int i = 0; i < 65540; i++) tick();
    chk("sat_mc", miss_count, 32'hFFFF);

    // Reset while a response is pending
    reset = 1; tick();
    chk("rst_valid", resp_valid, 0); chk("rst_mc", miss_count, 0);
    reset = 0; resp_ready = 0; tick();

    // Randomized traffic against the model
    idle();
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] va;
      reset = ($urandom_range(0, 399) == 0);
      flush = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 4) == 0)
        set_w($urandom_range(0, ENTRIES - 1), vpn_pool[$urandom_range(0, 3)],
              ASID_W'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
              VPN_W'($urandom), ($urandom_range(0, 5) != 0));
      else
        tlbw_en = 0;
      va = ($urandom_range(0, 9) < 6) ? {vpn_pool[$urandom_range(0, 3)], 12'($urandom)} : $urandom;
      set_req(va, ASID_W'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
      req_valid  = ($urandom_range(0, 9) < 8);
      resp_ready = ($urandom_range(0, 9) < 7);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
